// File: rtl/int_div_unit_if.sv
// Handshake and data bundle between the EX stage and the iterative divide unit.
// The pipeline side is the master; the divide unit is the slave.
interface int_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            done;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output start, funct3, op_a, op_b, kill,
    input  done, result, busy
  );

  modport slave (
    input  start, funct3, op_a, op_b, kill,
    output done, result, busy
  );
endinterface

// File: rtl/int_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Drives the pipeline-wide done/stall signal and holds the last result until the next load.
module int_div_unit #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  int_div_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic            sel_rem_q, quo_neg_q, rem_neg_q;

  // Issue-cycle decode: operand magnitudes, sign flags and the two special cases.
  logic            issue, is_signed, a_neg, b_neg, div_zero, overflow, special, last_step;
  logic [XLEN-1:0] abs_a, abs_b, special_result;

  always_comb begin
    issue          = bus.start && bus.funct3[2] && !bus.kill;
    is_signed      = !bus.funct3[0];
    a_neg          = is_signed && bus.op_a[XLEN-1];
    b_neg          = is_signed && bus.op_b[XLEN-1];
    abs_a          = a_neg ? -bus.op_a : bus.op_a;
    abs_b          = b_neg ? -bus.op_b : bus.op_b;
    div_zero       = (bus.op_b == '0);
    overflow       = is_signed && (bus.op_a == INT_MIN) && (bus.op_b == '1);
    special        = div_zero || overflow;
    special_result = div_zero ? (bus.funct3[1] ? bus.op_a : '1)
                              : (bus.funct3[1] ? '0 : INT_MIN);
    last_step      = (count_q == CW'(XLEN - 1));
  end

  // One restoring step: the XLEN+1-bit difference's MSB is the borrow of the trial subtract.
  logic [XLEN:0]   partial, diff;
  logic [XLEN-1:0] rem_next, quo_next, quo_fix, rem_fix, final_result;

  always_comb begin
    partial      = {rem_q, quo_q[XLEN-1]};
    diff         = partial - {1'b0, dvsr_q};
    rem_next     = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
    quo_next     = {quo_q[XLEN-2:0], ~diff[XLEN]};
    quo_fix      = quo_neg_q ? -quo_next : quo_next;
    rem_fix      = rem_neg_q ? -rem_next : rem_next;
    final_result = sel_rem_q ? rem_fix : quo_fix;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: all combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    bus.done = 1'b1;
    case (state_q)
      IDLE: begin
        if (issue) begin
          bus.done = 1'b0;
          state_d  = special ? DONE : BUSY;
        end
      end
      BUSY: begin
        bus.done = 1'b0;
        if (bus.kill)       state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: only the counter and result need a reset value; the working registers are
  // always reloaded at issue, so leaving them unreset saves reset fan-out for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            sel_rem_q <= bus.funct3[1];
            quo_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dvsr_q    <= abs_b;
            quo_q     <= abs_a;
            rem_q     <= '0;
            count_q   <= '0;
            if (special) result_q <= special_result;
          end
        end
        BUSY: begin
          if (!bus.kill) begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            count_q <= count_q + 1'b1;
            if (last_step) result_q <= final_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q == BUSY);
endmodule

// File: tb/tb_int_div_unit.sv
// Directed and randomized checks of int_div_unit: results, stall length, kill, reset.
module tb_int_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int_div_unit_if #(.XLEN(32)) bus ();
  int_div_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural RV32M semantics, written from the ISA definition.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F_DIV:   ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      F_DIVU:  ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM:   ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, count cycles with done low, check the DONE-cycle result.
  // With hold=1 start stays high into the next op (back-to-back).
  task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_low,
                         input bit hold);
    int low;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    #1;
    low = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) break;
      low++;
      @(negedge clk);
      #1;
    end
    check($sformatf("%s stall", tag), low, exp_low);
    check($sformatf("%s result", tag), bus.result, exp);
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check($sformatf("%s idle done", tag), bus.done, 1'b1);
      check($sformatf("%s idle result", tag), bus.result, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = F_DIVU; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset done", bus.done, 1'b1);
    check("reset busy", bus.busy, 1'b0);
    check("reset result", bus.result, 32'h0);
    reset = 1'b0;

    run_div("divu 100/7", F_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_div("remu 100/7", F_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_div("div -100/7", F_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
    run_div("rem -100/7", F_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
    run_div("rem 100/-7", F_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 1'b0);
    run_div("div 5/0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_div("remu 5/0", F_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_div("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_div("rem ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);

    // Back-to-back with start never dropping between the two ops.
    run_div("b2b first", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
    run_div("b2b second", F_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);
    @(negedge clk);
    #1;
    check("b2b no reissue", bus.done, 1'b1);

    // Kill at BUSY counter=10; result must keep the previous value (3).
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd10;
    repeat (11) @(negedge clk);
    #1;
    check("kill busy before", bus.busy, 1'b1);
    bus.kill = 1'b1; bus.start = 1'b0;
    #1;
    check("kill done in busy", bus.done, 1'b0);
    @(negedge clk);
    bus.kill = 1'b0;
    #1;
    check("kill done after", bus.done, 1'b1);
    check("kill busy after", bus.busy, 1'b0);
    check("kill result kept", bus.result, 32'd3);
    run_div("after kill", F_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b0);

    // Reset mid-BUSY, with operand changes during BUSY that must be ignored first.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F_DIV; bus.op_a = 32'hFFFF_FF9C; bus.op_b = 32'd7;
    repeat (5) @(negedge clk);
    bus.op_a = 32'd1; bus.op_b = 32'd1;
    repeat (2) @(negedge clk);
    reset = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    #1;
    check("midreset done", bus.done, 1'b1);
    check("midreset busy", bus.busy, 1'b0);
    check("midreset result", bus.result, 32'h0);
    reset = 1'b0;

    // Operand changes during BUSY are ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F_REMU; bus.op_a = 32'd50; bus.op_b = 32'd8;
    @(negedge clk);
    bus.op_a = 32'd7; bus.op_b = 32'd0;
    for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
    #1;
    check("sample-once result", bus.result, 32'd2);
    bus.start = 1'b0;

    // Random sweep against the architectural model.
    for (int n = 0; n < 24; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          lat;
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (n == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; f3 = F_REM; end
      lat = ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      run_div($sformatf("rand%0d f3=%b a=%h b=%h", n, f3, a, b), f3, a, b, ref_div(f3, a, b), lat, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
